modexp_sequencer: RTL

Controller that computes value^exponent mod modulus by right-to-left square-and-multiply. It drives one shared multi-cycle modulus unit through its ready/busy/valid handshake, one reduction per step. The multiply/square products are formed in the sequencer. Sits between the key-generation logic and the modulus block, replacing the single-shot exponentiate-then-reduce approach, which cannot hold large intermediates.

---
 rtl/modexp_pkg.sv | 35 +++
 rtl/modexp_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_EXP_WIDTH = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t RED_REQ  = 3'd1;
  localparam state_t RED_WAIT = 3'd2;
  localparam state_t MUL_REQ  = 3'd3;
  localparam state_t MUL_WAIT = 3'd4;
  localparam state_t SQR_REQ  = 3'd5;
  localparam state_t SQR_WAIT = 3'd6;
  localparam state_t DONE     = 3'd7;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RED,
    OP_MUL,
    OP_SQR
  } op_t;

  // Which modulus operation a state is working on; also useful as a debug tag.
  function automatic op_t state_op(state_t s);
    case (s)
      RED_REQ, RED_WAIT: return OP_RED;
      MUL_REQ, MUL_WAIT: return OP_MUL;
      SQR_REQ, SQR_WAIT: return OP_SQR;
      default:           return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/modexp_sequencer.sv
// Right-to-left square-and-multiply controller driving a shared modulus unit.
// Define MODEXP_EARLY_EXIT_EN to stop once no set exponent bits remain.
module modexp_sequencer
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   ready_in,
  input  logic [WIDTH-1:0]       value_in,
  input  logic [WIDTH-1:0]       modulus_in,
  input  logic [EXP_WIDTH-1:0]   exponent_in,
  output logic [WIDTH-1:0]       value_out,
  output logic                   busy_out,
  output logic                   valid_out,
  output logic                   error_out,
  output logic                   mod_ready_out,
  output logic [2*WIDTH-1:0]     mod_value_out,
  output logic [WIDTH-1:0]       mod_modulus_out,
  input  logic [2*WIDTH-1:0]     mod_value_in,
  input  logic                   mod_busy_in,
  input  logic                   mod_valid_in
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EXP_WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 error_q, error_d;

  op_t              op;
  logic [PW-1:0]    base_ext, result_ext;
  logic [WIDTH-1:0] rem;
  logic             unused_rem_hi;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_bit;
  logic             rest_zero;
  state_t           step_next, bit_next;

  assign op            = state_op(state_q);
  assign base_ext      = {{WIDTH{1'b0}}, base_q};
  assign result_ext    = {{WIDTH{1'b0}}, result_q};
  assign rem           = mod_value_in[WIDTH-1:0];
  assign unused_rem_hi = ^mod_value_in[PW-1:WIDTH];

  // Coming out of a square the loop moves on to the next bit.
  assign cur_idx = (state_q == SQR_WAIT) ? idx_q + 1'b1 : idx_q;
  assign cur_bit = exp_q[cur_idx];

`ifdef MODEXP_EARLY_EXIT_EN
  assign rest_zero = ((exp_q >> (32'(cur_idx) + 32'd1)) == '0);
`else
  assign rest_zero = 1'b0;
`endif

  // The final bit never needs its square: the squared base would go unused.
  assign step_next = ((cur_idx == LAST_IDX) || rest_zero) ? DONE : SQR_REQ;
  assign bit_next  = cur_bit ? MUL_REQ : step_next;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    result_d = result_q;
    mod_d    = mod_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    value_d  = value_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (ready_in) begin
          base_d   = value_in;
          mod_d    = modulus_in;
          exp_d    = exponent_in;
          idx_d    = '0;
          result_d = WIDTH'(1);
          state_d  = RED_REQ;
          if (modulus_in == '0 || modulus_in == WIDTH'(1)) begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      RED_REQ: if (!mod_busy_in) state_d = RED_WAIT;
      MUL_REQ: if (!mod_busy_in) state_d = MUL_WAIT;
      SQR_REQ: if (!mod_busy_in) state_d = SQR_WAIT;
      RED_WAIT: begin
        if (mod_valid_in) begin
          base_d  = rem;
          state_d = bit_next;
        end
      end
      MUL_WAIT: begin
        if (mod_valid_in) begin
          result_d = rem;
          state_d  = step_next;
        end
      end
      SQR_WAIT: begin
        if (mod_valid_in) begin
          base_d  = rem;
          idx_d   = idx_q + 1'b1;
          state_d = bit_next;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Result and error are published together on entry to DONE.
    if (state_d == DONE && state_q != DONE) begin
      value_d = result_d;
      error_d = (mod_d == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      base_q   <= '0;
      result_q <= '0;
      mod_q    <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      result_q <= result_d;
      mod_q    <= mod_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      error_q  <= error_d;
    end
  end

  // Operands only change on a remainder capture, so the dividend is stable
  // from REQ through WAIT.
  always_comb begin
    mod_value_out = '0;
    unique case (op)
      OP_RED:  mod_value_out = base_ext;
      OP_MUL:  mod_value_out = result_ext * base_ext;
      OP_SQR:  mod_value_out = base_ext * base_ext;
      default: mod_value_out = '0;
    endcase
  end

  assign mod_ready_out   = ((state_q == RED_REQ) || (state_q == MUL_REQ) ||
                            (state_q == SQR_REQ)) && !mod_busy_in;
  assign mod_modulus_out = mod_q;
  assign value_out       = value_q;
  assign error_out       = error_q;
  assign valid_out       = (state_q == DONE);
  assign busy_out        = (state_q != IDLE) && (state_q != DONE);

endmodule
